efb_wb_arbiter: RTL

EFB_WB_ARBITER -- requirements
Module: efb_wb_arbiter

---
 rtl/efb_wb_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/efb_wb_arbiter.sv
// Two-requester round-robin arbiter onto a single EFB wishbone port.
// Each access is latched, run on the bus until ack or timeout, then answered with a one-cycle ready.
module efb_wb_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [3:0]  r0_wstrb,
    input  logic [7:0]  r0_addr,
    input  logic [7:0]  r0_wdata,
    output logic [31:0] r0_rdata,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [3:0]  r1_wstrb,
    input  logic [7:0]  r1_addr,
    input  logic [7:0]  r1_wdata,
    output logic [31:0] r1_rdata,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [7:0]  wb_adr,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_ack,
    output logic [1:0]  grant,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    // Wait count reached in the last permitted BUS cycle (first BUS cycle sees zero).
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        last_served;
    logic        cyc;
    logic        pick1;
    logic [31:0] resp;
    logic        unused_strb;

    assign wb_cyc      = cyc;
    assign wb_stb      = cyc;
    assign unused_strb = ^{r0_wstrb[3:1], r1_wstrb[3:1]};

    always_comb begin
        pick1 = r1_valid;
        if (r0_valid && r1_valid)
            pick1 = ~last_served;
    end

    // An ack wins over the timeout when both land in the same cycle.
    assign resp = wb_ack ? {24'h0, wb_dat_i} : 32'h00BADADD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 8'h00;
            last_served <= 1'b1;
            cyc         <= 1'b0;
            wb_we       <= 1'b0;
            wb_adr      <= 8'h00;
            wb_dat_o    <= 8'h00;
            grant       <= 2'b00;
            r0_ready    <= 1'b0;
            r1_ready    <= 1'b0;
            r0_rdata    <= 32'h0;
            r1_rdata    <= 32'h0;
            err_timeout <= 1'b0;
        end else begin
            r0_ready    <= 1'b0;
            r1_ready    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (r0_valid || r1_valid) begin
                        wb_we       <= pick1 ? r1_wstrb[0] : r0_wstrb[0];
                        wb_adr      <= pick1 ? r1_addr : r0_addr;
                        wb_dat_o    <= pick1 ? r1_wdata : r0_wdata;
                        grant       <= pick1 ? 2'b10 : 2'b01;
                        last_served <= pick1;
                        wait_cnt    <= 8'h00;
                        cyc         <= 1'b1;
                        state       <= BUS;
                    end
                end
                BUS: begin
                    if (wb_ack || wait_cnt == LAST_WAIT) begin
                        cyc         <= 1'b0;
                        err_timeout <= ~wb_ack;
                        if (grant[1]) begin
                            r1_rdata <= resp;
                            r1_ready <= 1'b1;
                        end else begin
                            r0_rdata <= resp;
                            r0_ready <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h01;
                    end
                end
                DONE: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
